control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Hard-wired control unit upstream of the ALU datapath system; drives every datapath control input (RF, ARF, ALU, IR, memory, muxes).
- Fetches each 16-bit instruction as two little-endian bytes, then decodes IR and executes in a single cycle.
- Returns to fetch after execute. HLT parks the sequencer until reset.

Parameters:
- none (all encodings are fixed constants in the shared package)

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high
- IROut  in  16  instruction register contents
- FlagsOut  in  4  ALU flags {Z,C,N,O}, bit3=Z
- RF_OutASel, RF_OutBSel  out  3 each  000..011 = R1..R4
- RF_FunSel  out  3  010 load, 011 clear
- RF_RegSel  out  4  one-hot active-high enable, bit3=R1 … bit0=R4
- RF_ScrSel  out  4  always 0000
- ALU_FunSel  out  5  10000 A, 10100 A+B, 10110 A-B, 10111 AND, 11000 OR, 11001 XOR
- ALU_WF  out  1  flag write enable
- ARF_OutCSel, ARF_OutDSel  out  2 each  00 PC, 10 AR, 11 SP
- ARF_FunSel  out  3  001 inc, 010 load, 011 clear
- ARF_RegSel  out  3  one-hot enable, bit2=PC, bit1=AR, bit0=SP
- IR_LH  out  1  0 = load low byte, 1 = load high byte
- IR_Write  out  1  IR load enable
- Mem_WR  out  1  1 = write
- Mem_CS  out  1  active-low chip select
- MuxASel, MuxBSel  out  2 each  00 ALUOut, 01 OutC, 10 MemOut, 11 IR[7:0]
- MuxCSel  out  1  0 = ALUOut[7:0]
- State  out  3  debug: current state code

Behaviour:
- States: RST=0, F0=1, F1=2, EX=3, HALT=4. Next-state transitions occur on the rising edge of Clock. Outputs are a combinational function of state, IROut and FlagsOut.
- Idle defaults apply to any field not listed for a state: all RegSel=0, IR_Write=0, Mem_CS=1, Mem_WR=0, ALU_WF=0, mux selects and FunSels=0.
- Reset high: state forced to RST immediately (asynchronous), including mid-fetch or mid-execute. Outputs take RST values in the same cycle.
- RST: ARF_FunSel=011, ARF_RegSel=111; RF_FunSel=011, RF_RegSel=1111. Next state F0.
- F0: ARF_OutDSel=00, Mem_CS=0, IR_Write=1, IR_LH=0, ARF_FunSel=001, ARF_RegSel=100. Next state F1.
- F1: same as F0 but IR_LH=1. Next state EX. The instruction is valid in IR from the EX cycle onward.
- EX: decode IR[15:10]. Next state F0, except HLT goes to HALT.
- HALT: idle defaults; stays in HALT until reset.
- Field rules:
  - RSel = IR[9:8], 00..11 = R1..R4.
  - ALU format: S = IR[9] drives ALU_WF; DST = IR[8:6]; SRC1 = IR[5:3]; SRC2 = IR[2:0]. Codes 1xx = R1..R4.
  - Source select = {0, code[1:0]}.
  - DST with code 0xx: no write (RF_RegSel=0000); ALU_WF still honoured.
- Opcodes (EX actions):
  - 00 BRA: MuxBSel=11, ARF_FunSel=010, ARF_RegSel=100 (PC <- {8'h00, IR[7:0]}).
  - 01 BNE: as BRA if Z=0, else idle.
  - 02 BEQ: as BRA if Z=1, else idle.
  - 03 LD: ARF_OutDSel=10, Mem_CS=0, MuxASel=10, RF_FunSel=010, RegSel=onehot(RSel).
  - 04 ST: RF_OutASel={0,RSel}, ALU_FunSel=10000, MuxCSel=0, ARF_OutDSel=10, Mem_CS=0, Mem_WR=1.
  - 05 MOVL: MuxASel=11, RF_FunSel=010, RegSel=onehot(RSel).
  - 06 MOV: ALU_FunSel=10000, MuxASel=00, RF load to DST.
  - 07 ADD, 08 SUB, 09 AND, 0A ORR, 0B XOR: A=SRC1, B=SRC2, corresponding ALU_FunSel, MuxASel=00, RF load to DST.
  - 0C HLT: idle, next state HALT.
  - Any other opcode: NOP (idle, next state F0).
- PC advances by 2 per instruction; PC wraps from FFFF to 0000.

Decomposition:
- Package cpu_ctrl_pkg:
  - state enum
  - opcode constants
  - ALU/RF/ARF FunSel constants
  - mux select constants
  - RegSel one-hot constants
- Sub-module instr_decoder: purely combinational; maps (IROut, FlagsOut) to the EX-state control word.
- control_sequencer: state register, state muxing of the control word, idle defaults.

Test Plan:
- Assert Reset during F1 -> State=0 the same cycle, IR_Write=0. Release Reset -> RST cycle shows ARF_RegSel=111, ARF_FunSel=011, then F0 shows ARF_OutDSel=00, Mem_CS=0, IR_LH=0.
- IROut=0x155A (MOVL R2,0x5A) in EX -> MuxASel=11, RF_FunSel=010, RF_RegSel=0100; next state F0.
- IROut=0x1F2E (ADD S=1, R1<-R2+R3) in EX -> ALU_FunSel=10100, ALU_WF=1, RF_OutASel=001, RF_OutBSel=010, MuxASel=00, RF_RegSel=1000.
- IROut=0x0840 (BEQ 0x40):
  - FlagsOut=4'b1000 -> MuxBSel=11, ARF_FunSel=010, ARF_RegSel=100.
  - FlagsOut=4'b0000 -> ARF_RegSel=000.
- IROut=0x1140 (ST R2) -> RF_OutASel=001, ALU_FunSel=10000, ARF_OutDSel=10, Mem_CS=0, Mem_WR=1.
- IROut=0x3000 (HLT) -> State=4 held for 20 cycles with Mem_CS=1, all RegSel=0; opcode 0x3F gives a NOP and returns to F0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hard-wired control sequencer: states, opcodes,
// function selects, mux selects and the packed control word.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_F0   = 3'd1,
        S_F1   = 3'd2,
        S_EX   = 3'd3,
        S_HALT = 3'd4
    } state_t;

    localparam logic [5:0] OP_BRA  = 6'h00;
    localparam logic [5:0] OP_BNE  = 6'h01;
    localparam logic [5:0] OP_BEQ  = 6'h02;
    localparam logic [5:0] OP_LD   = 6'h03;
    localparam logic [5:0] OP_ST   = 6'h04;
    localparam logic [5:0] OP_MOVL = 6'h05;
    localparam logic [5:0] OP_MOV  = 6'h06;
    localparam logic [5:0] OP_ADD  = 6'h07;
    localparam logic [5:0] OP_SUB  = 6'h08;
    localparam logic [5:0] OP_AND  = 6'h09;
    localparam logic [5:0] OP_ORR  = 6'h0A;
    localparam logic [5:0] OP_XOR  = 6'h0B;
    localparam logic [5:0] OP_HLT  = 6'h0C;

    localparam logic [4:0] ALU_PASS_A = 5'b10000;
    localparam logic [4:0] ALU_ADD    = 5'b10100;
    localparam logic [4:0] ALU_SUB    = 5'b10110;
    localparam logic [4:0] ALU_AND    = 5'b10111;
    localparam logic [4:0] ALU_OR     = 5'b11000;
    localparam logic [4:0] ALU_XOR    = 5'b11001;

    localparam logic [2:0] RF_FUN_LOAD   = 3'b010;
    localparam logic [2:0] RF_FUN_CLEAR  = 3'b011;
    localparam logic [2:0] ARF_FUN_INC   = 3'b001;
    localparam logic [2:0] ARF_FUN_LOAD  = 3'b010;
    localparam logic [2:0] ARF_FUN_CLEAR = 3'b011;

    localparam logic [1:0] MUX_ALU  = 2'b00;
    localparam logic [1:0] MUX_OUTC = 2'b01;
    localparam logic [1:0] MUX_MEM  = 2'b10;
    localparam logic [1:0] MUX_IRL  = 2'b11;

    localparam logic [1:0] ARF_SEL_PC = 2'b00;
    localparam logic [1:0] ARF_SEL_AR = 2'b10;
    localparam logic [1:0] ARF_SEL_SP = 2'b11;

    localparam logic [3:0] RF_REGSEL_NONE  = 4'b0000;
    localparam logic [3:0] RF_REGSEL_ALL   = 4'b1111;
    localparam logic [2:0] ARF_REGSEL_NONE = 3'b000;
    localparam logic [2:0] ARF_REGSEL_PC   = 3'b100;
    localparam logic [2:0] ARF_REGSEL_ALL  = 3'b111;

    typedef struct packed {
        logic [2:0] rf_out_a_sel;
        logic [2:0] rf_out_b_sel;
        logic [2:0] rf_fun_sel;
        logic [3:0] rf_reg_sel;
        logic [3:0] rf_scr_sel;
        logic [4:0] alu_fun_sel;
        logic       alu_wf;
        logic [1:0] arf_out_c_sel;
        logic [1:0] arf_out_d_sel;
        logic [2:0] arf_fun_sel;
        logic [2:0] arf_reg_sel;
        logic       ir_lh;
        logic       ir_write;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] mux_a_sel;
        logic [1:0] mux_b_sel;
        logic       mux_c_sel;
    } ctrl_word_t;

    // Idle word: nothing enabled, memory deselected (chip select is active-low).
    function automatic ctrl_word_t idle_word();
        ctrl_word_t w;
        w        = '0;
        w.mem_cs = 1'b1;
        return w;
    endfunction

    // R1 sits at bit 3 of RegSel, R4 at bit 0.
    function automatic logic [3:0] rf_onehot(input logic [1:0] idx);
        return 4'b1000 >> idx;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bus between the sequencer (master) and the ALU datapath (slave),
// carrying IR/flags back from the datapath and every datapath control field.
interface control_sequencer_if;
    logic [15:0] IROut;
    logic [3:0]  FlagsOut;
    logic [2:0]  RF_OutASel;
    logic [2:0]  RF_OutBSel;
    logic [2:0]  RF_FunSel;
    logic [3:0]  RF_RegSel;
    logic [3:0]  RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [1:0]  ARF_OutCSel;
    logic [1:0]  ARF_OutDSel;
    logic [2:0]  ARF_FunSel;
    logic [2:0]  ARF_RegSel;
    logic        IR_LH;
    logic        IR_Write;
    logic        Mem_WR;
    logic        Mem_CS;
    logic [1:0]  MuxASel;
    logic [1:0]  MuxBSel;
    logic        MuxCSel;
    logic [2:0]  State;

    modport master (
        input  IROut, FlagsOut,
        output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
               ALU_FunSel, ALU_WF,
               ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
               IR_LH, IR_Write, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel, State
    );

    modport slave (
        output IROut, FlagsOut,
        input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
               ALU_FunSel, ALU_WF,
               ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
               IR_LH, IR_Write, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel, State
    );
endinterface

// File: rtl/instr_decoder.sv
// Purely combinational decode of IR (and the Z flag) into the control word
// used during the execute cycle, plus a halt request for HLT.
module instr_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [15:0] ir,
    input  logic [3:0]  flags,
    output ctrl_word_t  ex_word,
    output logic        halt
);

    logic [5:0] opcode;
    logic [1:0] rsel;
    logic [2:0] dst;
    logic [1:0] src1;
    logic [1:0] src2;
    logic       zero;
    logic       branch_taken;
    logic [4:0] alu_op;
    logic       unused_bits;

    assign opcode = ir[15:10];
    assign rsel   = ir[9:8];
    assign dst    = ir[8:6];
    assign src1   = ir[4:3];
    assign src2   = ir[1:0];
    assign zero   = flags[3];

    // Only Z steers branches; the top bit of each ALU source code is implied.
    assign unused_bits = ^{flags[2:0], ir[5], ir[2]};

    assign branch_taken = (opcode == OP_BRA)
                        | ((opcode == OP_BNE) & ~zero)
                        | ((opcode == OP_BEQ) &  zero);

    always_comb begin
        alu_op = ALU_PASS_A;
        case (opcode)
            OP_ADD:  alu_op = ALU_ADD;
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            OP_ORR:  alu_op = ALU_OR;
            OP_XOR:  alu_op = ALU_XOR;
            default: alu_op = ALU_PASS_A;
        endcase
    end

    always_comb begin
        ex_word = idle_word();
        halt    = 1'b0;
        case (opcode)
            OP_BRA, OP_BNE, OP_BEQ: begin
                if (branch_taken) begin
                    ex_word.mux_b_sel   = MUX_IRL;
                    ex_word.arf_fun_sel = ARF_FUN_LOAD;
                    ex_word.arf_reg_sel = ARF_REGSEL_PC;
                end
            end
            OP_LD: begin
                ex_word.arf_out_d_sel = ARF_SEL_AR;
                ex_word.mem_cs        = 1'b0;
                ex_word.mux_a_sel     = MUX_MEM;
                ex_word.rf_fun_sel    = RF_FUN_LOAD;
                ex_word.rf_reg_sel    = rf_onehot(rsel);
            end
            OP_ST: begin
                ex_word.rf_out_a_sel  = {1'b0, rsel};
                ex_word.alu_fun_sel   = ALU_PASS_A;
                ex_word.mux_c_sel     = 1'b0;
                ex_word.arf_out_d_sel = ARF_SEL_AR;
                ex_word.mem_cs        = 1'b0;
                ex_word.mem_wr        = 1'b1;
            end
            OP_MOVL: begin
                ex_word.mux_a_sel  = MUX_IRL;
                ex_word.rf_fun_sel = RF_FUN_LOAD;
                ex_word.rf_reg_sel = rf_onehot(rsel);
            end
            // MOV passes SRC1 straight through; the others also read SRC2.
            OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_XOR: begin
                ex_word.alu_wf       = ir[9];
                ex_word.alu_fun_sel  = alu_op;
                ex_word.rf_out_a_sel = {1'b0, src1};
                if (opcode != OP_MOV) begin
                    ex_word.rf_out_b_sel = {1'b0, src2};
                end
                ex_word.mux_a_sel = MUX_ALU;
                if (dst[2]) begin
                    ex_word.rf_fun_sel = RF_FUN_LOAD;
                    ex_word.rf_reg_sel = rf_onehot(dst[1:0]);
                end
            end
            OP_HLT: begin
                halt = 1'b1;
            end
            default: begin
                halt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hard-wired control unit: RST -> F0 -> F1 -> EX loop with a terminal HALT,
// fetching each instruction as low byte then high byte.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic                 Clock,
    input  logic                 Reset,
    control_sequencer_if.master  bus
);

    state_t     state;
    state_t     next_state;
    ctrl_word_t ex_word;
    ctrl_word_t cw;
    logic       halt_req;

    instr_decoder u_decoder (
        .ir      (bus.IROut),
        .flags   (bus.FlagsOut),
        .ex_word (ex_word),
        .halt    (halt_req)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_RST;
        end else begin
            state <= next_state;
        end
    end

    // Fetch reads memory at PC and bumps PC once per byte, so PC moves by 2.
    always_comb begin
        next_state = state;
        cw         = idle_word();
        case (state)
            S_RST: begin
                cw.arf_fun_sel = ARF_FUN_CLEAR;
                cw.arf_reg_sel = ARF_REGSEL_ALL;
                cw.rf_fun_sel  = RF_FUN_CLEAR;
                cw.rf_reg_sel  = RF_REGSEL_ALL;
                next_state     = S_F0;
            end
            S_F0, S_F1: begin
                cw.arf_out_d_sel = ARF_SEL_PC;
                cw.mem_cs        = 1'b0;
                cw.ir_write      = 1'b1;
                cw.ir_lh         = (state == S_F1);
                cw.arf_fun_sel   = ARF_FUN_INC;
                cw.arf_reg_sel   = ARF_REGSEL_PC;
                next_state       = (state == S_F0) ? S_F1 : S_EX;
            end
            S_EX: begin
                cw         = ex_word;
                next_state = halt_req ? S_HALT : S_F0;
            end
            S_HALT: begin
                next_state = S_HALT;
            end
            default: begin
                next_state = S_RST;
            end
        endcase
    end

    assign bus.RF_OutASel  = cw.rf_out_a_sel;
    assign bus.RF_OutBSel  = cw.rf_out_b_sel;
    assign bus.RF_FunSel   = cw.rf_fun_sel;
    assign bus.RF_RegSel   = cw.rf_reg_sel;
    assign bus.RF_ScrSel   = cw.rf_scr_sel;
    assign bus.ALU_FunSel  = cw.alu_fun_sel;
    assign bus.ALU_WF      = cw.alu_wf;
    assign bus.ARF_OutCSel = cw.arf_out_c_sel;
    assign bus.ARF_OutDSel = cw.arf_out_d_sel;
    assign bus.ARF_FunSel  = cw.arf_fun_sel;
    assign bus.ARF_RegSel  = cw.arf_reg_sel;
    assign bus.IR_LH       = cw.ir_lh;
    assign bus.IR_Write    = cw.ir_write;
    assign bus.Mem_WR      = cw.mem_wr;
    assign bus.Mem_CS      = cw.mem_cs;
    assign bus.MuxASel     = cw.mux_a_sel;
    assign bus.MuxBSel     = cw.mux_b_sel;
    assign bus.MuxCSel     = cw.mux_c_sel;
    assign bus.State       = state;

endmodule
